// File: rtl/evm_pkg.sv
// Shared types and constants for the voting-machine display scheduler.
// Holds the scheduler state encoding and the blank/off display codes.
package evm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [1:0] AN_OFF    = 2'b11;
    localparam int         CAND_W    = 2;

endpackage

// File: rtl/evm_tick_gen.sv
// Modulo-N counter with synchronous clear and count enable.
// tick is high during the enabled cycle in which the count sits at N-1.
module evm_tick_gen #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] cnt;
    logic         at_end;

    assign at_end = (cnt == W'(N - 1));
    assign tick   = en && at_end;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_end ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/evm_display_scheduler.sv
// Rotates per-candidate vote counts onto the shared two-digit decoder and
// scans the decoder's ones/tens segments onto one common-anode bus.
module evm_display_scheduler
    import evm_pkg::*;
#(
    parameter int NUM_CAND     = 4,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int SCAN_CYCLES  = 50_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [4*NUM_CAND-1:0] votes_flat,
    input  logic                  hold_req,
    input  logic [CAND_W-1:0]     hold_sel,
    input  logic [6:0]            led1,
    input  logic [6:0]            led2,
    output logic [3:0]            dec_votes,
    output logic [CAND_W-1:0]     cand_idx,
    output logic [NUM_CAND-1:0]   cand_led,
    output logic [6:0]            seg,
    output logic [1:0]            an,
    output logic                  rot_tick,
    output state_t                dbg_state
);

    state_t                state, nxt_state;
    logic                  digit, nxt_digit;
    logic [CAND_W-1:0]     nxt_idx, hold_idx, adv_idx;
    logic                  nxt_rot;
    logic [3:0]            nxt_votes;
    logic [NUM_CAND-1:0]   nxt_led;
    logic                  dwell_en, dwell_tick;
    logic                  scan_en, scan_tick;

    // Dwell only runs in uninterrupted SHOW; any hold request or state change
    // clears it, so the count restarts from 0 after leaving HOLD.
    assign dwell_en = enable && (state == SHOW) && !hold_req;
    assign scan_en  = enable && (state != IDLE);

    evm_tick_gen #(.N(DWELL_CYCLES)) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!dwell_en),
        .en    (dwell_en),
        .tick  (dwell_tick)
    );

    evm_tick_gen #(.N(SCAN_CYCLES)) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!scan_en),
        .en    (scan_en),
        .tick  (scan_tick)
    );

    assign hold_idx = (int'(hold_sel) >= NUM_CAND) ? CAND_W'(NUM_CAND - 1) : hold_sel;
    assign adv_idx  = (int'(cand_idx) == NUM_CAND - 1) ? '0 : cand_idx + CAND_W'(1);

    always_comb begin
        nxt_state = state;
        nxt_idx   = cand_idx;
        nxt_digit = digit;
        nxt_rot   = 1'b0;
        if (!enable) begin
            nxt_state = IDLE;
            nxt_idx   = '0;
            nxt_digit = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    nxt_state = SHOW;
                    nxt_idx   = '0;
                    nxt_digit = 1'b0;
                end
                SHOW: begin
                    if (scan_tick) nxt_digit = !digit;
                    if (hold_req) begin
                        nxt_state = HOLD;
                        nxt_idx   = hold_idx;
                    end else if (dwell_tick) begin
                        nxt_idx = adv_idx;
                        nxt_rot = 1'b1;
                    end
                end
                HOLD: begin
                    if (scan_tick) nxt_digit = !digit;
                    if (hold_req) nxt_idx = hold_idx;
                    else          nxt_state = SHOW;
                end
                default: begin
                    nxt_state = IDLE;
                    nxt_idx   = '0;
                    nxt_digit = 1'b0;
                end
            endcase
        end
    end

    // Count and indicator come from the next index so they land on the same
    // edge as cand_idx itself.
    always_comb begin
        nxt_votes = '0;
        nxt_led   = '0;
        for (int k = 0; k < NUM_CAND; k++) begin
            if (nxt_idx == CAND_W'(k)) begin
                nxt_votes  = votes_flat[4*k +: 4];
                nxt_led[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand_idx  <= '0;
            digit     <= 1'b0;
            rot_tick  <= 1'b0;
            dec_votes <= '0;
            cand_led  <= '0;
            an        <= AN_OFF;
        end else begin
            state     <= nxt_state;
            cand_idx  <= nxt_idx;
            digit     <= nxt_digit;
            rot_tick  <= nxt_rot;
            dec_votes <= (nxt_state == IDLE) ? 4'd0 : nxt_votes;
            cand_led  <= (nxt_state == IDLE) ? '0 : nxt_led;
            an        <= (nxt_state == IDLE) ? AN_OFF : (nxt_digit ? 2'b01 : 2'b10);
        end
    end

    assign seg       = (state == IDLE) ? SEG_BLANK : (digit ? led2 : led1);
    assign dbg_state = state;

endmodule

// File: tb/tb_evm_display_scheduler.sv
// Bench for evm_display_scheduler: segment table of input phases with
// hand-derived end expectations, plus a per-cycle expected-output queue.
module tb_evm_display_scheduler;
    import evm_pkg::*;

    localparam int NC = 3;
    localparam int DW = 8;
    localparam int SC = 2;
    localparam int EW = 4 + 2 + NC + 2 + 7 + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic            hold_req = 1'b0;
    logic [1:0]      hold_sel = 2'd0;
    logic [4*NC-1:0] votes_flat = {4'd12, 4'd7, 4'd3};
    logic [6:0]      led1 = 7'h00;
    logic [6:0]      led2 = 7'h00;
    logic [3:0]      dec_votes;
    logic [1:0]      cand_idx;
    logic [NC-1:0]   cand_led;
    logic [6:0]      seg;
    logic [1:0]      an;
    logic            rot_tick;
    state_t          dbg_state;

    evm_display_scheduler #(
        .NUM_CAND     (NC),
        .DWELL_CYCLES (DW),
        .SCAN_CYCLES  (SC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .votes_flat (votes_flat),
        .hold_req   (hold_req),
        .hold_sel   (hold_sel),
        .led1       (led1),
        .led2       (led2),
        .dec_votes  (dec_votes),
        .cand_idx   (cand_idx),
        .cand_led   (cand_led),
        .seg        (seg),
        .an         (an),
        .rot_tick   (rot_tick),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rot_seen = 0;

    // Reference timeline: ages measured in clock edges since SHOW entry
    // (dwell) and since the display was lit (scan).
    state_t m_mode = IDLE;
    int     m_idx = 0;
    int     show_age = 0;
    int     scan_age = 0;

    task automatic model_step(input logic r, input logic e, input logic h, input logic [1:0] s);
        logic [3:0]    v;
        logic [NC-1:0] l;
        logic [1:0]    a;
        logic [6:0]    sg;
        logic          rt;
        int            sel;
        int            dig;
        rt  = 1'b0;
        sel = (int'(s) >= NC) ? NC - 1 : int'(s);
        if (!r || !e) begin
            m_mode = IDLE;
            m_idx  = 0;
        end else if (m_mode == IDLE) begin
            m_mode   = SHOW;
            m_idx    = 0;
            show_age = 0;
            scan_age = 0;
        end else begin
            scan_age++;
            if (m_mode == SHOW) begin
                if (h) begin
                    m_mode = HOLD;
                    m_idx  = sel;
                end else begin
                    show_age++;
                    if (show_age == DW) begin
                        show_age = 0;
                        m_idx    = (m_idx + 1) % NC;
                        rt       = 1'b1;
                    end
                end
            end else if (h) begin
                m_idx = sel;
            end else begin
                m_mode   = SHOW;
                show_age = 0;
            end
        end
        if (m_mode == IDLE) begin
            v  = 4'd0;
            l  = '0;
            a  = 2'b11;
            sg = 7'h7F;
        end else begin
            dig = (scan_age / SC) % 2;
            v   = votes_flat[4*m_idx +: 4];
            l   = NC'(1) << m_idx;
            a   = (dig == 1) ? 2'b01 : 2'b10;
            sg  = (dig == 1) ? led2 : led1;
        end
        exp_q.push_back({v, 2'(m_idx), l, a, sg, rt});
    endtask

    task automatic check_outputs();
        logic [EW-1:0] exp_w;
        logic [EW-1:0] act_w;
        act_w = {dec_votes, cand_idx, cand_led, an, seg, rot_tick};
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL queue_empty cycle %0d: no expected entry", cyc);
        end else begin
            exp_w = exp_q.pop_front();
            n_cmp++;
            if (act_w !== exp_w) begin
                n_bad++;
                $display("FAIL cycle_%0d: got votes=%0d idx=%0d led=%b an=%b seg=%h rot=%b, want votes=%0d idx=%0d led=%b an=%b seg=%h rot=%b",
                         cyc, dec_votes, cand_idx, cand_led, an, seg, rot_tick,
                         exp_w[EW-1 -: 4], exp_w[EW-5 -: 2], exp_w[EW-7 -: NC],
                         exp_w[9:8], exp_w[7:1], exp_w[0]);
            end
        end
        if (rot_tick === 1'b1) rot_seen++;
    endtask

    task automatic drive(input logic r, input logic e, input logic h,
                         input logic [1:0] s, input logic [3:0] v1);
        @(negedge clk);
        rst_n      = r;
        enable     = e;
        hold_req   = h;
        hold_sel   = s;
        votes_flat = {4'd12, v1, 4'd3};
        led1       = 7'($urandom_range(0, 127));
        led2       = 7'($urandom_range(0, 127));
        model_step(r, e, h, s);
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    typedef struct {
        logic       r;
        logic       e;
        logic       h;
        logic [1:0] s;
        int         n;
        logic [3:0] v1;
        int         end_idx;
        int         rots;
        state_t     st;
    } seg_t;

    seg_t tbl[15];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, 3,  4'd7, 0, 0, IDLE};  // reset held
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 4,  4'd7, 0, 0, IDLE};  // stays blank
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 2'd0, 25, 4'd7, 0, 3, SHOW};  // 0,1,2,0 with wrap
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 2'd0, 3,  4'd7, 0, 0, SHOW};  // mid-dwell
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 2'd3, 20, 4'd7, 2, 0, HOLD};  // clamped hold
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 2'd3, 9,  4'd7, 0, 1, SHOW};  // release: 8 cycles then 0
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 2'd0, 7,  4'd7, 0, 0, SHOW};  // dwell reaches 7
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1,  4'd7, 1, 0, HOLD};  // hold beats rotation
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 2'd0, 2,  4'd7, 0, 0, HOLD};  // reselect while held
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 2'd0, 2,  4'd7, 0, 0, IDLE};  // disable in HOLD
        tbl[10] = '{1'b1, 1'b1, 1'b0, 2'd0, 5,  4'd7, 0, 0, SHOW};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 2'd0, 1,  4'd7, 0, 0, IDLE};  // reset mid-SHOW
        tbl[12] = '{1'b1, 1'b1, 1'b0, 2'd0, 10, 4'd7, 1, 1, SHOW};  // restart from 0
        tbl[13] = '{1'b1, 1'b1, 1'b0, 2'd0, 3,  4'd5, 1, 0, SHOW};  // live count change
        tbl[14] = '{1'b1, 1'b0, 1'b0, 2'd0, 2,  4'd7, 0, 0, IDLE};

        for (int i = 0; i < 15; i++) begin
            rot_seen = 0;
            for (int c = 0; c < tbl[i].n; c++) begin
                drive(tbl[i].r, tbl[i].e, tbl[i].h, tbl[i].s, tbl[i].v1);
            end
            n_cmp++;
            if (int'(cand_idx) != tbl[i].end_idx) begin
                n_bad++;
                $display("FAIL seg%0d_end_idx: got %0d want %0d", i, cand_idx, tbl[i].end_idx);
            end
            n_cmp++;
            if (rot_seen != tbl[i].rots) begin
                n_bad++;
                $display("FAIL seg%0d_rot_count: got %0d want %0d", i, rot_seen, tbl[i].rots);
            end
            n_cmp++;
            if (dbg_state !== tbl[i].st) begin
                n_bad++;
                $display("FAIL seg%0d_state: got %0d want %0d", i, dbg_state, tbl[i].st);
            end
        end

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
